// File: rtl/led_pwm_counter_if.sv
// led_pwm_counter_if: control, threshold and status bundle for led_pwm_counter.
interface led_pwm_counter_if #(parameter int WIDTH = 8, parameter int NUM_CH = 2);
   logic                      en;
   logic                      up;
   logic                      sat;
   logic                      load;
   logic [WIDTH-1:0]          load_val;
   logic [WIDTH-1:0]          top;
   logic [NUM_CH*WIDTH-1:0]   thr;
   logic [WIDTH-1:0]          count;
   logic [NUM_CH-1:0]         led;
   logic                      tc;
   logic [1:0]                state;
   modport master (output en, up, sat, load, load_val, top, thr, input count, led, tc, state);
   modport slave  (input en, up, sat, load, load_val, top, thr, output count, led, tc, state);
endinterface

// File: rtl/led_pwm_counter.sv
// led_pwm_counter: up/down wrap-or-saturate counter with per-channel PWM LED compare.
module led_pwm_counter #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 2
) (
   input logic              clk,
   input logic              rst,
   led_pwm_counter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} st_t;
   st_t              st, st_n;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic [NUM_CH-1:0] led, led_n;
   logic             tc, tc_n;
   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      tc_n  = 1'b0;
      if (bus.load) begin
         cnt_n = (bus.load_val > bus.top) ? bus.top : bus.load_val;
         st_n  = IDLE;
      end else begin
         case (st)
            IDLE: st_n = bus.en ? RUN : IDLE;
            RUN: if (bus.en) begin
               // out-of-range count (top lowered), end of range up or down all end the same way
               if (cnt > bus.top || (bus.up ? cnt == bus.top : cnt == '0)) begin
                  tc_n  = 1'b1;
                  st_n  = bus.sat ? HOLD : RUN;
                  cnt_n = (cnt > bus.top) ? bus.top : bus.sat ? cnt : bus.up ? '0 : bus.top;
               end else begin
                  cnt_n = bus.up ? cnt + 1'b1 : cnt - 1'b1;
               end
            end
            HOLD: st_n = bus.sat ? HOLD : RUN;
            default: st_n = IDLE;
         endcase
      end
      led_n = '0;
      for (int i = 0; i < NUM_CH; i++) led_n[i] = cnt_n < bus.thr[i*WIDTH +: WIDTH];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st  <= IDLE;
         cnt <= '0;
         led <= '0;
         tc  <= 1'b0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
         led <= led_n;
         tc  <= tc_n;
      end
   end
   assign bus.count = cnt;
   assign bus.led   = led;
   assign bus.tc    = tc;
   assign bus.state = st;
endmodule

// File: tb/tb_led_pwm_counter.sv
// tb_led_pwm_counter: directed scoreboard bench for led_pwm_counter.
module tb_led_pwm_counter;
   typedef struct {
      logic [7:0] c;
      logic [1:0] l;
      logic       t;
      logic [1:0] s;
      string      tag;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   hi0, hi1;
   logic [7:0] thr0 = 8'd2;
   logic [7:0] thr1 = 8'd7;
   exp_t q[$];
   led_pwm_counter_if #(.WIDTH(8), .NUM_CH(2)) bus ();
   led_pwm_counter #(.WIDTH(8), .NUM_CH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic e, u, s, l, input logic [7:0] lv, c, input logic t,
                       input logic [1:0] st, input string tag);
      exp_t x;
      bus.en = e; bus.up = u; bus.sat = s; bus.load = l; bus.load_val = lv;
      bus.thr = {thr1, thr0};
      x.c = c; x.t = t; x.s = st; x.tag = tag;
      x.l = {c < thr1, c < thr0};
      q.push_back(x);
      @(posedge clk);
      #1;
      x = q.pop_front();
      chk({x.tag, "_count"}, 16'(bus.count), 16'(x.c));
      chk({x.tag, "_led"},   16'(bus.led),   16'(x.l));
      chk({x.tag, "_tc"},    16'(bus.tc),    16'(x.t));
      chk({x.tag, "_state"}, 16'(bus.state), 16'(x.s));
   endtask
   initial begin
      bus.en = 1'b0; bus.up = 1'b1; bus.sat = 1'b0; bus.load = 1'b0;
      bus.load_val = 8'd0; bus.top = 8'd5; bus.thr = {thr1, thr0};
      #2;
      chk("reset_count", 16'(bus.count), 16'd0);
      chk("reset_led",   16'(bus.led),   16'd0);
      chk("reset_tc",    16'(bus.tc),    16'd0);
      chk("reset_state", 16'(bus.state), 16'd0);
      #1 rst = 1'b1;
      step(1, 1, 0, 0, 0, 0, 0, 2'b01, "start");
      for (int i = 1; i <= 12; i++) step(1, 1, 0, 0, 0, 8'(i % 6), (i % 6) == 0, 2'b01, "wrap_up");
      bus.top = 8'd9;
      hi0 = 0; hi1 = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1, 1, 0, 0, 0, 8'(i % 10), (i % 10) == 0, 2'b01, "pwm");
         hi0 += int'(bus.led[0]);
         hi1 += int'(bus.led[1]);
      end
      chk("pwm_led0_high", 16'(hi0), 16'd2);
      chk("pwm_led1_high", 16'(hi1), 16'd7);
      for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, 0, 8'(i), 0, 2'b01, "to4");
      step(1, 1, 0, 1, 200, 9, 0, 2'b00, "load_clamp");
      step(1, 1, 0, 1, 3, 3, 0, 2'b00, "load_plain");
      step(1, 1, 0, 0, 0, 3, 0, 2'b01, "restart");
      bus.top = 8'd3;
      step(1, 1, 1, 0, 0, 3, 1, 2'b10, "sat_hit");
      for (int i = 0; i < 10; i++) step(1, i[0], 1, 0, 0, 3, 0, 2'b10, "hold");
      step(1, 1, 0, 0, 0, 3, 0, 2'b01, "hold_exit");
      step(1, 1, 0, 0, 0, 0, 1, 2'b01, "post_hold_wrap");
      bus.top = 8'd4;
      step(1, 0, 0, 0, 0, 4, 1, 2'b01, "down_wrap");
      for (int i = 3; i >= 0; i--) step(1, 0, 0, 0, 0, 8'(i), 0, 2'b01, "down");
      step(1, 0, 0, 0, 0, 4, 1, 2'b01, "down_wrap2");
      step(0, 1, 0, 0, 0, 4, 0, 2'b01, "en_low");
      bus.top = 8'd2;
      step(1, 1, 0, 0, 0, 2, 1, 2'b01, "clamp_wrap");
      bus.top = 8'd1;
      step(1, 0, 1, 0, 0, 1, 1, 2'b10, "clamp_sat");
      bus.top = 8'd0;
      step(1, 1, 0, 1, 7, 0, 0, 2'b00, "load_top0");
      step(1, 1, 0, 0, 0, 0, 0, 2'b01, "top0_start");
      step(1, 1, 0, 0, 0, 0, 1, 2'b01, "top0_wrap");
      step(1, 0, 0, 0, 0, 0, 1, 2'b01, "top0_wrap2");
      step(1, 1, 1, 0, 0, 0, 1, 2'b10, "top0_sat");
      step(1, 1, 1, 0, 0, 0, 0, 2'b10, "top0_hold");
      bus.top = 8'd4;
      step(0, 0, 1, 1, 2, 2, 0, 2'b00, "load2");
      step(1, 0, 1, 0, 0, 2, 0, 2'b01, "dsat_start");
      step(1, 0, 1, 0, 0, 1, 0, 2'b01, "dsat_1");
      step(1, 0, 1, 0, 0, 0, 0, 2'b01, "dsat_0");
      step(1, 0, 1, 0, 0, 0, 1, 2'b10, "dsat_hit");
      bus.top = 8'd9;
      step(1, 1, 0, 1, 3, 3, 0, 2'b00, "pre_rst_load");
      step(1, 1, 0, 0, 0, 3, 0, 2'b01, "pre_rst_run");
      step(1, 1, 0, 0, 0, 4, 0, 2'b01, "pre_rst_4");
      #2 rst = 1'b0;
      #1;
      chk("async_count", 16'(bus.count), 16'd0);
      chk("async_led",   16'(bus.led),   16'd0);
      chk("async_tc",    16'(bus.tc),    16'd0);
      chk("async_state", 16'(bus.state), 16'd0);
      #1 rst = 1'b1;
      step(1, 1, 0, 1, 5, 5, 0, 2'b00, "post_rst_load");
      step(1, 1, 0, 0, 0, 5, 0, 2'b01, "post_rst_start");
      chk("queue_empty", 16'(q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/led_pwm_counter.md
LED_PWM_COUNTER -- requirements
Module: led_pwm_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and threshold width; legal range 2..16.
REQ-002 Parameter NUM_CH, default 2: number of LED channels; legal range 1..8.
REQ-003 clk  input  1  Single clock; all state updates on rising edge.
REQ-004 rst  input  1  Asynchronous, active-low reset.
REQ-005 en  input  1  Count enable.
REQ-006 up  input  1  Direction: 1 = count up, 0 = count down.
REQ-007 sat  input  1  End-of-range mode: 1 = saturate, 0 = wrap.
REQ-008 load  input  1  Synchronous load strobe.
REQ-009 load_val  input  WIDTH  Value applied on load.
REQ-010 top  input  WIDTH  Terminal count; count range is 0..top inclusive.
REQ-011 thr  input  NUM_CH*WIDTH  Per-channel duty threshold; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 count  output  WIDTH  Registered counter value.
REQ-013 led  output  NUM_CH  Registered LED drives.
REQ-014 tc  output  1  Registered terminal-count pulse.
REQ-015 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HOLD; 11 unused.

Function
REQ-016 FSM IDLE -> RUN on any edge with en=1 and load=0; count does not step on that edge (one-cycle start latency).
REQ-017 In RUN, each edge with en=1 steps count by one in the direction set by up; en=0 holds count and state.
REQ-018 Up step: count<top -> count+1; count==top, sat=0 -> 0 with tc=1; count==top, sat=1 -> hold at top, go HOLD, tc=1.
REQ-019 Down step: count>0 -> count-1; count==0, sat=0 -> top with tc=1; count==0, sat=1 -> hold at 0, go HOLD, tc=1.
REQ-020 If count>top (top lowered at run time), the next enabled step loads top.
- This applies in either direction and either mode.
- tc=1 on that step.
- If sat=1, state goes to HOLD.
REQ-021 HOLD: count frozen regardless of en or up, tc held 0; sat=0 returns to RUN on the next edge without stepping.
REQ-022 load=1 has priority over every other input in every state:
- count <= load_val, or top if load_val>top.
- state <= IDLE.
- tc <= 0.
REQ-023 top==0: an enabled step in RUN keeps count 0 and asserts tc.
- sat=0: tc asserts every enabled cycle.
- sat=1: tc asserts once, then state is HOLD.
REQ-024 tc is high for exactly the one cycle following the edge that produced the wrap, saturation or clamp; otherwise 0.
REQ-025 led[i] is registered on every edge as (next count < thr_i).
- led therefore always equals (count < thr_i) for a static thr.
- thr_i==0 -> led[i] constantly 0.
- thr_i>top -> led[i] constantly 1.
REQ-026 All comparisons and arithmetic are unsigned WIDTH-bit; no carry or borrow is visible outside the wrap/saturate rules.
REQ-027 State encoding 11 is never entered; if reached, the next edge goes to IDLE with count held.

Reset
REQ-028 rst=0 immediately, without a clock edge, forces count=0, led=0, tc=0, state=IDLE.
REQ-029 Reset asserted mid-operation discards the count in progress; no tc is produced by the reset.
REQ-030 After rst rises, the first edge follows REQ-016; a load on that edge is honoured.

Verification
REQ-031 Start-up and wrap: WIDTH=8, top=5, up=1, sat=0, en=1 after reset.
- count sequence: 0 (IDLE edge), 1, 2, 3, 4, 5, 0, 1, ...
- tc is high only in the cycles where count shows 0 after a wrap, once per 6 steps.
REQ-032 Saturate up: top=3, sat=1.
- count reaches 3; state=HOLD; single tc pulse.
- count stays 3 for 10 cycles with en=1.
- Drop sat: state=RUN; next enabled edge gives count=0 with tc=1.
REQ-033 Down wrap: top=4, up=0, count=0, RUN, en=1 -> count=4, tc=1; following edges give 3, 2, 1, 0, 4.
REQ-034 PWM: top=9, wrap, thr ch0=2, ch1=7.
- led[0] high for count 0..1.
- led[1] high for count 0..6.
- Over 10 steps: led[0] high 2 cycles, led[1] high 7 cycles.
REQ-035 Load clamp: in RUN at count=4, top=9, load=1, load_val=200, en=1 -> next cycle count=9, state=IDLE, tc=0.
REQ-036 Async reset: at count=4 in RUN, drive rst=0 between edges -> count, led, tc and state read 0 before the next clock edge.
